// File: rtl/sram_pkg.sv
// Shared types and helpers for the masked 1RW SRAM model and its array core.
package sram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   // Width of one write-mask granule.
   function automatic int granule_w(input int data_w, input int mask_w);
      return data_w / mask_w;
   endfunction

   // Legal parameter set: mask must evenly split the word, at least two entries.
   function automatic bit params_ok(input int data_w, input int mask_w, input int depth);
      return (mask_w > 0) && ((data_w % mask_w) == 0) && (depth >= 2);
   endfunction

endpackage

// File: rtl/sram_1rw_masked_core.sv
// Pure storage array: per-granule masked write and registered read, no reset.
// Replace this module to map onto a technology macro.
module sram_1rw_masked_core
   import sram_pkg::*;
#(
   parameter int DATA_W = 36,
   parameter int DEPTH  = 2048,
   parameter int MASK_W = 6,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [MASK_W-1:0] wmask,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int GRAN_W = granule_w(DATA_W, MASK_W);

   logic [DATA_W-1:0] mem [DEPTH];

   // Masked write of enabled granules; read data registered on re only.
   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (wmask[i]) begin
               mem[addr][i*GRAN_W +: GRAN_W] <= wdata[i*GRAN_W +: GRAN_W];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/sram_1rw_masked_init.sv
// Masked 1RW SRAM with valid/ready requests, held read response and an
// optional post-reset sweep that fills every entry with INIT_VALUE.
module sram_1rw_masked_init
   import sram_pkg::*;
#(
   parameter int                DATA_W     = 36,
   parameter int                DEPTH      = 2048,
   parameter int                MASK_W     = 6,
   parameter bit                INIT_EN    = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   localparam int               ADDR_W     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wmode,
   input  logic [MASK_W-1:0] req_wmask,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done
);

   if (!params_ok(DATA_W, MASK_W, DEPTH)) begin : g_param_check
      $error("sram_1rw_masked_init: DATA_W must be divisible by MASK_W and DEPTH must be >= 2");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t            state_q;
   state_t            state_nxt;
   logic [ADDR_W-1:0] init_cnt_q;
   logic              ready_q;
   logic              resp_valid_q;
   logic              rdata_zero_q;
   logic              accept;
   logic              in_range;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] core_rdata;

   assign in_range = {1'b0, req_addr} < DEPTH_EXT;
   assign accept   = req_valid && ready_q;

   // State and sweep counter; the counter only advances while sweeping.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= INIT_EN ? ST_INIT : ST_IDLE;
         init_cnt_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
         end
      end
   end

   // Next state and array port arbitration: sweep owns the port in INIT.
   always_comb begin
      state_nxt = state_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = req_addr;
      mem_wmask = req_wmask;
      mem_wdata = req_wdata;
      if (state_q == ST_INIT) begin
         mem_we    = reset_n;
         mem_addr  = init_cnt_q;
         mem_wmask = '1;
         mem_wdata = INIT_VALUE;
         if (init_cnt_q == LAST_ADDR) begin
            state_nxt = ST_IDLE;
         end
      end else begin
         mem_we = reset_n && accept && req_wmode && in_range;
         mem_re = reset_n && accept && !req_wmode && in_range;
      end
   end

   // Registered handshake/response flags; rdata_zero_q forces 0 after reset and
   // for out-of-range reads so the output never shows stale or undefined data.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         rdata_zero_q <= 1'b1;
      end else begin
         ready_q      <= (state_nxt == ST_IDLE);
         resp_valid_q <= accept && !req_wmode;
         if (accept && !req_wmode) begin
            rdata_zero_q <= !in_range;
         end
      end
   end

   sram_1rw_masked_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .MASK_W (MASK_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clock (clock),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wmask (mem_wmask),
      .wdata (mem_wdata),
      .rdata (core_rdata)
   );

   assign req_ready  = ready_q;
   assign init_done  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_zero_q ? '0 : core_rdata;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Bench for sram_1rw_masked_init with a 12-entry (non-power-of-two) array.
module tb_sram_1rw_masked_init;

   localparam int          DW  = 36;
   localparam int          DEP = 12;
   localparam int          MW  = 6;
   localparam int          AW  = 4;
   localparam logic [35:0] IV  = 36'hA5;

   typedef struct {
      logic [35:0] data;
      int          cyc;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_wmode = 1'b0;
   logic [MW-1:0] req_wmask = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          init_done;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   exp_t          sb[$];
   logic [35:0]   model [DEP];

   sram_1rw_masked_init #(
      .DATA_W     (DW),
      .DEPTH      (DEP),
      .MASK_W     (MW),
      .INIT_EN    (1'b1),
      .INIT_VALUE (IV)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wmode  (req_wmode),
      .req_wmask  (req_wmask),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .init_done  (init_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every response must match the oldest expected read, on time.
   always @(negedge clock) begin
      if (resp_valid === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp rdata=%h cyc=%0d (no read outstanding)", resp_rdata, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (resp_rdata !== e.data || cyc != e.cyc) begin
               bad++;
               $display("FAIL read_resp got=%h at cyc %0d, want=%h at cyc %0d",
                        resp_rdata, cyc, e.data, e.cyc);
            end
         end
      end
   end

   function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] d,
                                         input logic [5:0] m);
      logic [35:0] r;
      r = old;
      for (int i = 0; i < 6; i++) begin
         if (m[i]) r[i*6 +: 6] = d[i*6 +: 6];
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle(input int n);
      req_valid = 1'b0;
      req_wmode = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_wmode = 1'b1;
      req_addr  = a;
      req_wmask = m;
      req_wdata = d;
      if (int'(a) < DEP) model[a] = merge(model[a], d, m);
      step();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      exp_t e;
      req_valid = 1'b1;
      req_wmode = 1'b0;
      req_addr  = a;
      req_wmask = '0;
      e.data = (int'(a) < DEP) ? model[a] : 36'h0;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      step();
   endtask

   // Runs n edges with reset_n high, optionally with ignored requests present,
   // checking that ready/init_done rise exactly on edge DEP of the sweep.
   task automatic run_sweep(input int n, input bit noise);
      for (int k = 1; k <= n; k++) begin
         if (noise) begin
            req_valid = 1'b1;
            req_wmode = k[0];
            req_addr  = '0;
            req_wmask = '1;
            req_wdata = 36'hFFFFFFFFF;
         end
         step();
         total++;
         if (req_ready !== logic'(k == DEP) || init_done !== logic'(k == DEP)) begin
            bad++;
            $display("FAIL sweep_ready edge=%0d ready=%b init_done=%b want=%b",
                     k, req_ready, init_done, (k == DEP));
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_idle(3);
      total++;
      if (req_ready !== 1'b0 || init_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready ready=%b init_done=%b want=0", req_ready, init_done);
      end
      total++;
      if (resp_valid !== 1'b0 || resp_rdata !== 36'h0) begin
         bad++;
         $display("FAIL reset_resp valid=%b rdata=%h want 0/0", resp_valid, resp_rdata);
      end
      reset_n = 1'b1;
      for (int i = 0; i < DEP; i++) model[i] = IV;
      run_sweep(DEP, 1'b0);
   endtask

   task automatic test_init_reads();
      for (int a = 0; a < DEP; a++) do_read(AW'(a));
      drive_idle(2);
   endtask

   task automatic test_masked_write();
      do_write(4'd3, 6'b111111, 36'h0);
      do_write(4'd3, 6'b000101, 36'hFFFFFFFFF);
      do_read(4'd3);
      do_write(4'd3, 6'b000000, 36'h123456789);
      do_read(4'd3);
      do_write(4'd6, 6'b100000, 36'hFFFFFFFFF);
      do_read(4'd6);
      drive_idle(2);
   endtask

   task automatic test_hold();
      do_write(4'd5, 6'b111111, 36'h11);
      do_read(4'd5);
      do_write(4'd5, 6'b111111, 36'h22);
      for (int i = 0; i < 3; i++) begin
         drive_idle(1);
         total++;
         if (resp_valid !== 1'b0 || resp_rdata !== 36'h11) begin
            bad++;
            $display("FAIL hold idle=%0d valid=%b rdata=%h want 0/%h", i, resp_valid, resp_rdata, 36'h11);
         end
      end
      do_read(4'd5);
      drive_idle(2);
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [8];
      logic [63:0]   rnd;
      addrs = '{4'd0, 4'd11, 4'd1, 4'd7, 4'd2, 4'd9, 4'd4, 4'd10};
      for (int i = 0; i < 8; i++) begin
         rnd = {$urandom(), $urandom()};
         do_write(addrs[i], MW'($urandom_range(1, 63)), rnd[35:0]);
         do_read(addrs[i]);
      end
      drive_idle(2);
   endtask

   task automatic test_out_of_range();
      do_write(4'd13, 6'b111111, 36'hFFFFFFFFF);
      do_read(4'd13);
      do_read(4'd1);
      do_write(4'd12, 6'b111111, 36'h5A5A5A5A5);
      do_read(4'd12);
      do_read(4'd0);
      do_read(4'd15);
      do_read(4'd11);
      drive_idle(2);
   endtask

   task automatic test_reset_mid_sweep();
      reset_n = 1'b0;
      drive_idle(1);
      reset_n = 1'b1;
      run_sweep(6, 1'b1);
      reset_n = 1'b0;
      drive_idle(1);
      reset_n = 1'b1;
      for (int i = 0; i < DEP; i++) model[i] = IV;
      run_sweep(DEP, 1'b1);
      for (int a = 0; a < DEP; a++) do_read(AW'(a));
      drive_idle(2);
   endtask

   initial begin
      test_reset();
      test_init_reads();
      test_masked_write();
      test_hold();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_sweep();
      drive_idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL outstanding_reads left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
